// File: rtl/axi4_master_pkg.sv
// Shared types and constants for the AXI4 burst arbiter and its sub-blocks.
//   - arb_state_t    : sequencer state encoding
//   - AXI_4K_SHIFT   : log2 of the AXI page size that a burst must not cross
//   - bytes_per_beat : bytes moved per data beat for a given bus width
//   - RESP_*         : AXI xRESP encodings used by the burst engine
package axi4_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_CPL = 2'd2,
      ST_RESP     = 2'd3
   } arb_state_t;

   localparam int AXI_4K_SHIFT = 12;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic int bytes_per_beat(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/axi4_burst_arbiter_rr_arbiter.sv
// Combinational round-robin grant selection.
// Ports:
//   req       in  NUM_REQ    request vector
//   rr_ptr    in  IDX_WIDTH  highest-priority requester for this round
//   grant     out NUM_REQ    one-hot grant (zero when no request)
//   grant_idx out IDX_WIDTH  encoded index of the granted requester
//   grant_any out 1          at least one request present
module rr_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [IDX_WIDTH-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]   grant,
   output logic [IDX_WIDTH-1:0] grant_idx,
   output logic                 grant_any
);

   logic [IDX_WIDTH-1:0] cand;

   // Walk from rr_ptr upward with wrap; the first set request wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IDX_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
         if (!grant_any && req[cand]) begin
            grant_any   = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/axi4_burst_arbiter.sv
// Shares one AXI4 burst engine between NUM_REQ requesters. One command is
// accepted per grant (round-robin), bursts crossing a 4 KB page are rejected
// without touching the engine, accepted commands are issued and their
// completion awaited under a watchdog, and the owner gets a done/error pulse.
//
// Ports:
//   M_AXI_ACLK     in  1                   clock
//   M_AXI_ARESETN  in  1                   async active-low reset
//   REQ_VALID      in  NUM_REQ             per-requester command valid
//   REQ_READY      out NUM_REQ             one-hot accept, combinational in IDLE
//   REQ_WRITE      in  NUM_REQ             1=write burst, 0=read burst
//   REQ_ADDR       in  NUM_REQ*ADDR_WIDTH  start address, slice per requester
//   REQ_LEN        in  NUM_REQ*8           AXI LEN, slice per requester
//   REQ_DONE       out NUM_REQ             one-cycle completion pulse to owner
//   REQ_ERROR      out NUM_REQ             valid with REQ_DONE, 1=failed
//   CMD_VALID      out 1                   command to burst engine
//   CMD_READY      in  1                   engine accepts command
//   CMD_WRITE      out 1                   latched direction
//   CMD_ADDR       out ADDR_WIDTH          latched address
//   CMD_LEN        out 8                   latched LEN
//   CMD_ID         out IDX_WIDTH           owner index
//   CPL_VALID      in  1                   engine completion pulse
//   CPL_ERROR      in  1                   engine reported a failure
//   BUSY           out 1                   sequencer not idle
//   TIMEOUT_FLAG   out 1                   sticky watchdog expiry
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | waiting for a request; grant + 4 KB check combinational
// ST_ISSUE    | CMD_VALID high, fields frozen until CMD_READY
// ST_WAIT_CPL | command with engine; watchdog running
// ST_RESP     | DONE/ERROR pulse to owner, round-robin pointer advances
module axi4_burst_arbiter
   import axi4_master_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int IDX_WIDTH      = $clog2(NUM_REQ)
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESETN,
   input  logic [NUM_REQ-1:0]            REQ_VALID,
   output logic [NUM_REQ-1:0]            REQ_READY,
   input  logic [NUM_REQ-1:0]            REQ_WRITE,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [NUM_REQ*8-1:0]          REQ_LEN,
   output logic [NUM_REQ-1:0]            REQ_DONE,
   output logic [NUM_REQ-1:0]            REQ_ERROR,
   output logic                          CMD_VALID,
   input  logic                          CMD_READY,
   output logic                          CMD_WRITE,
   output logic [ADDR_WIDTH-1:0]         CMD_ADDR,
   output logic [7:0]                    CMD_LEN,
   output logic [IDX_WIDTH-1:0]          CMD_ID,
   input  logic                          CPL_VALID,
   input  logic                          CPL_ERROR,
   output logic                          BUSY,
   output logic                          TIMEOUT_FLAG
);

   localparam int BPB   = bytes_per_beat(DATA_WIDTH);
   localparam int AW1   = ADDR_WIDTH + 1;
   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD =
      TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

   arb_state_t           state;
   logic [IDX_WIDTH-1:0] rr_ptr;
   logic [TMR_W-1:0]     tmr;

   logic [NUM_REQ-1:0]   grant;
   logic [IDX_WIDTH-1:0] grant_idx;
   logic                 grant_any;

   logic                  sel_write;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [7:0]            sel_len;
   logic [AW1-1:0]        burst_bytes;
   logic [AW1-1:0]        end_addr;
   logic                  cross_4k;
   logic [NUM_REQ-1:0]    owner_onehot;
   logic [IDX_WIDTH-1:0]  next_ptr;

   rr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_rr_arbiter (
      .req       (REQ_VALID),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign sel_write = REQ_WRITE[grant_idx];
   assign sel_addr  = REQ_ADDR[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_len   = REQ_LEN[int'(grant_idx)*8 +: 8];

   // One extra bit so a burst wrapping past the top of the address space
   // shows up as a page change in the shifted compare below.
   assign burst_bytes = (AW1'({1'b0, sel_len}) + AW1'(1)) * AW1'(BPB);
   assign end_addr    = {1'b0, sel_addr} + burst_bytes - AW1'(1);
   assign cross_4k    = (end_addr >> AXI_4K_SHIFT) != ({1'b0, sel_addr} >> AXI_4K_SHIFT);

   // Gated by reset so a requester holding VALID through reset sees no accept.
   assign REQ_READY = (state == ST_IDLE && M_AXI_ARESETN) ? grant : '0;

   assign owner_onehot = NUM_REQ'(1) << CMD_ID;
   assign next_ptr     = (CMD_ID == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : CMD_ID + IDX_WIDTH'(1);

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state        <= ST_IDLE;
         rr_ptr       <= '0;
         tmr          <= '0;
         REQ_DONE     <= '0;
         REQ_ERROR    <= '0;
         CMD_VALID    <= 1'b0;
         CMD_WRITE    <= 1'b0;
         CMD_ADDR     <= '0;
         CMD_LEN      <= '0;
         CMD_ID       <= '0;
         BUSY         <= 1'b0;
         TIMEOUT_FLAG <= 1'b0;
      end else begin
         REQ_DONE  <= '0;
         REQ_ERROR <= '0;
         case (state)
            ST_IDLE: begin
               if (grant_any) begin
                  CMD_WRITE <= sel_write;
                  CMD_ADDR  <= sel_addr;
                  CMD_LEN   <= sel_len;
                  CMD_ID    <= grant_idx;
                  BUSY      <= 1'b1;
                  if (cross_4k) begin
                     // Rejected: the pulse is loaded now so it is visible in RESP.
                     state     <= ST_RESP;
                     REQ_DONE  <= grant;
                     REQ_ERROR <= grant;
                  end else begin
                     state     <= ST_ISSUE;
                     CMD_VALID <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               if (CMD_READY) begin
                  CMD_VALID <= 1'b0;
                  tmr       <= TMR_LOAD;
                  state     <= ST_WAIT_CPL;
               end
            end
            ST_WAIT_CPL: begin
               // Completion is tested first so it wins over a coincident expiry.
               if (CPL_VALID) begin
                  state     <= ST_RESP;
                  REQ_DONE  <= owner_onehot;
                  REQ_ERROR <= CPL_ERROR ? owner_onehot : '0;
               end else if (WD_EN && tmr == '0) begin
                  state        <= ST_RESP;
                  REQ_DONE     <= owner_onehot;
                  REQ_ERROR    <= owner_onehot;
                  TIMEOUT_FLAG <= 1'b1;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            ST_RESP: begin
               rr_ptr <= next_ptr;
               BUSY   <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/axi4_burst_arbiter.md
Name: axi4_burst_arbiter

Overview:
Round-robin arbiter and sequencer that shares one AXI4 burst master engine between NUM_REQ requesters. It accepts one burst command per grant and rejects bursts that cross a 4 KB boundary. It issues accepted commands to the engine's command port and waits for completion, with a watchdog. It returns a per-requester done/error pulse. Sits between user-side DMA clients and the AXI4 master (M00_AXI) burst engine; one command outstanding at a time.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, AXI data width; bytes per beat = DATA_WIDTH/8
TIMEOUT_CYCLES, 4096, watchdog limit in WAIT_CPL; 0 disables
IDX_WIDTH, $clog2(NUM_REQ), requester index width

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESETN  in  1  asynchronous active-low reset
REQ_VALID  in  NUM_REQ  per-requester command valid, held until accepted
REQ_READY  out  NUM_REQ  one-hot accept (combinational grant in IDLE)
REQ_WRITE  in  NUM_REQ  1=write burst, 0=read burst
REQ_ADDR  in  NUM_REQ*ADDR_WIDTH  start address, requester i at slice i
REQ_LEN  in  NUM_REQ*8  AXI LEN (beats-1), requester i at slice i
REQ_DONE  out  NUM_REQ  one-cycle completion pulse to owner
REQ_ERROR  out  NUM_REQ  valid with REQ_DONE; 1=failed
CMD_VALID  out  1  command to burst engine
CMD_READY  in  1  engine accepts command
CMD_WRITE  out  1  latched direction
CMD_ADDR  out  ADDR_WIDTH  latched address
CMD_LEN  out  8  latched LEN
CMD_ID  out  IDX_WIDTH  owner index
CPL_VALID  in  1  engine completion pulse
CPL_ERROR  in  1  engine saw SLVERR/DECERR or data mismatch
BUSY  out  1  state != IDLE
TIMEOUT_FLAG  out  1  sticky; set on watchdog expiry, cleared only by reset

Behaviour:
- Reset (async assert, sync release): state IDLE; rr_ptr=0; all outputs 0; CMD_* fields 0; timer 0; TIMEOUT_FLAG 0.
- FSM states: IDLE, ISSUE, WAIT_CPL, RESP.
- IDLE, grant selection:
  - Winner = first i with REQ_VALID[i], searching from rr_ptr upward with wrap modulo NUM_REQ.
  - REQ_READY[winner]=1 in the same cycle; no other bit set. No request: REQ_READY=0, stay.
  - On the accepting edge, latch write/addr/len/owner.
- IDLE, 4 KB check: end = addr + (len+1)*(DATA_WIDTH/8) - 1. Compute with ADDR_WIDTH+1 bits.
  - If end[ADDR_WIDTH-1:12] != addr[ADDR_WIDTH-1:12], or the sum carries out: err=1, go RESP, engine untouched.
  - Otherwise go ISSUE.
- ISSUE: CMD_VALID=1, CMD_* stable until CMD_READY; on handshake go WAIT_CPL, CMD_VALID=0 next cycle, timer cleared.
- WAIT_CPL:
  - Timer increments each cycle.
  - CPL_VALID: err=CPL_ERROR, go RESP.
  - Timer reaching TIMEOUT_CYCLES-1 without CPL: err=1, TIMEOUT_FLAG=1, go RESP.
  - CPL_VALID and expiry in the same cycle: CPL wins, no flag.
- RESP: REQ_DONE[owner]=1 and REQ_ERROR[owner]=err for exactly one cycle; rr_ptr=(owner+1) mod NUM_REQ; go IDLE.
- CPL_VALID outside WAIT_CPL is ignored.
- Minimum latency, accept to DONE: 3 cycles with CMD_READY=1 and CPL_VALID one cycle after the command handshake. A rejected (4 KB) request reaches DONE 1 cycle after accept.
- Back-to-back: the next grant is possible in the cycle after RESP.
- A requester deasserting REQ_VALID before grant is legal; it is simply not granted.
- Reset mid-operation: immediate return to IDLE, no DONE emitted; the engine is reset by the same ARESETN.

Decomposition:
- Package axi4_master_pkg: state enum; AXI_4K_SHIFT=12; BYTES_PER_BEAT function; resp encodings OKAY/EXOKAY/SLVERR/DECERR.
- One sub-module, rr_arbiter: inputs NUM_REQ request vector and rr_ptr; output one-hot grant and encoded index; purely combinational.

Test Plan:
- Single request: NUM_REQ=2, requester 0 writes addr 0x10000000, LEN=15; engine ready, CPL after 20 cycles -> CMD_ADDR=0x10000000, CMD_LEN=15, CMD_ID=0; REQ_DONE[0] pulse with REQ_ERROR[0]=0; rr_ptr=1.
- Fairness: both REQ_VALID held continuously, 4 transactions -> grant order 0,1,0,1; each DONE goes to its owner only.
- 4 KB reject: addr 0x10000FC0, LEN=16 (68 bytes, ends 0x10001003) -> CMD_VALID never asserts; REQ_DONE/REQ_ERROR=1 one cycle after accept. Addr 0x10000FC0, LEN=15 -> issued normally.
- Engine error and stall: CMD_READY held low 10 cycles -> CMD fields stable throughout; then CPL_ERROR=1 -> REQ_ERROR=1.
- Watchdog: TIMEOUT_CYCLES=16, no CPL -> DONE+ERROR 16 cycles after command handshake, TIMEOUT_FLAG=1. CPL coincident with expiry -> ERROR=0, flag stays 0.
- Reset mid-WAIT_CPL: ARESETN low asynchronously -> all outputs 0 immediately, no DONE. After release, requester 1 pending is granted first because rr_ptr=0 and requester 0 is idle.
